// File: rtl/mem_port_arbiter.sv
// Two-requester sequencer for a single memory port: arbitrates, issues one command, waits RD_LAT, returns read data.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: requester 0 always wins a tie instead of round-robin.
module mem_port_arbiter #(
  parameter int PC_WIDTH  = 32,
  parameter int REG_WIDTH = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [PC_WIDTH-1:0]  adr0,
  input  logic [PC_WIDTH-1:0]  adr1,
  input  logic [REG_WIDTH-1:0] wdata0,
  input  logic [REG_WIDTH-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [REG_WIDTH-1:0] rdata,
  output logic                 memWe,
  output logic                 memRd,
  output logic [PC_WIDTH-1:0]  memAdr,
  output logic [REG_WIDTH-1:0] memwrData,
  input  logic [REG_WIDTH-1:0] memrdData
);

  localparam logic [3:0] LAT = 4'(RD_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESP} state_e;

  state_e               state_q, state_d;
  logic                 lp_q, lp_d;
  logic                 owner_q, owner_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                 rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                 mem_we_q, mem_we_d, mem_rd_q, mem_rd_d;
  logic [PC_WIDTH-1:0]  mem_adr_q, mem_adr_d;
  logic [REG_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [REG_WIDTH-1:0] rdata_q, rdata_d;
  logic                 any_req;
  logic                 win1;
  logic                 sel_we;

  assign any_req = req0 | req1;

  // win1 = 1 selects requester 1; a lone requester always wins.
  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    win1 = req1 & ~req0;
`else
    win1 = req1 & (~req0 | ~lp_q);
`endif
    sel_we = win1 ? we1 : we0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lp_q        <= 1'b1;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      lp_q        <= lp_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      mem_we_q    <= mem_we_d;
      mem_rd_q    <= mem_rd_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = mem_we_q ? IDLE : RWAIT;
      RWAIT:   if (cnt_q == LAT) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded one cycle ahead, so each pulse lands in the state it belongs to.
  always_comb begin
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    lp_d        = lp_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt0_d      = ~win1;
          gnt1_d      = win1;
          mem_we_d    = sel_we;
          mem_rd_d    = ~sel_we;
          mem_adr_d   = win1 ? adr1 : adr0;
          mem_wdata_d = win1 ? wdata1 : wdata0;
          lp_d        = win1;
          owner_d     = win1;
          cnt_d       = '0;
        end
      end
      ISSUE: cnt_d = 4'd1;
      RWAIT: begin
        if (cnt_q == LAT) begin
          rdata_d   = memrdData;
          rvalid0_d = ~owner_q;
          rvalid1_d = owner_q;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = rdata_q;
  assign memWe     = mem_we_q;
  assign memRd     = mem_rd_q;
  assign memAdr    = mem_adr_q;
  assign memwrData = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RD_LAT=1 instance for most scenarios, RD_LAT=3 instance for latency.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] adr0, adr1, wdata0, wdata1, memrdData;

  logic        gnt0, gnt1, rvalid0, rvalid1, memWe, memRd;
  logic [31:0] rdata, memAdr, memwrData;
  logic        gnt0_l3, gnt1_l3, rvalid0_l3, rvalid1_l3, memWe_l3, memRd_l3;
  logic [31:0] rdata_l3, memAdr_l3, memwrData_l3;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] GARB = 32'hBAD0_BAD0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.PC_WIDTH(32), .REG_WIDTH(32), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .memWe(memWe), .memRd(memRd), .memAdr(memAdr), .memwrData(memwrData),
    .memrdData(memrdData)
  );

  mem_port_arbiter #(.PC_WIDTH(32), .REG_WIDTH(32), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_l3), .gnt1(gnt1_l3), .rvalid0(rvalid0_l3), .rvalid1(rvalid1_l3), .rdata(rdata_l3),
    .memWe(memWe_l3), .memRd(memRd_l3), .memAdr(memAdr_l3), .memwrData(memwrData_l3),
    .memrdData(memrdData)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0;
    memrdData = GARB;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    vectors++;
    if ({gnt0, gnt1, rvalid0, rvalid1, memWe, memRd} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_strobes got=%b exp=000000", {gnt0, gnt1, rvalid0, rvalid1, memWe, memRd});
    end
    vectors++;
    if ({memAdr, memwrData, rdata} !== 96'b0) begin
      miscompares++;
      $display("FAIL reset_data got=%h exp=0", {memAdr, memwrData, rdata});
    end
    vectors++;
    if ({gnt0_l3, gnt1_l3, rvalid0_l3, rvalid1_l3, memWe_l3, memRd_l3} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_strobes_l3 got=%b exp=000000",
               {gnt0_l3, gnt1_l3, rvalid0_l3, rvalid1_l3, memWe_l3, memRd_l3});
    end
    reset = 0;
  endtask

  task automatic test_single_read();
    apply_reset();
    req0 = 1; we0 = 0; adr0 = 32'h100;
    tick();  // cycle 1
    vectors++;
    if ({gnt0, gnt1, memRd, memWe} !== 4'b1010 || memAdr !== 32'h100) begin
      miscompares++;
      $display("FAIL read_c1 got g0g1RdWe=%b adr=%h exp=1010 adr=100", {gnt0, gnt1, memRd, memWe}, memAdr);
    end
    req0 = 0;
    tick();  // cycle 2: data valid this cycle
    memrdData = 32'hDEAD_BEEF;
    vectors++;
    if ({gnt0, memRd, memWe, rvalid0} !== 4'b0000) begin
      miscompares++;
      $display("FAIL read_c2 got g0RdWeRv=%b exp=0000", {gnt0, memRd, memWe, rvalid0});
    end
    tick();  // cycle 3
    memrdData = GARB;
    vectors++;
    if ({rvalid0, rvalid1, memWe} !== 3'b100 || rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL read_c3 got rv0rv1We=%b rdata=%h exp=100 rdata=deadbeef", {rvalid0, rvalid1, memWe}, rdata);
    end
    tick();  // cycle 4
    vectors++;
    if (rvalid0 !== 1'b0 || memWe !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL read_c4_hold got rv0=%b We=%b rdata=%h exp rv0=0 We=0 rdata=deadbeef", rvalid0, memWe, rdata);
    end
  endtask

  task automatic test_single_write();
    apply_reset();
    req1 = 1; we1 = 1; adr1 = 32'h20; wdata1 = 32'h1234_5678;
    tick();  // cycle 1
    vectors++;
    if ({gnt0, gnt1, memWe, memRd} !== 4'b0110 || memAdr !== 32'h20 || memwrData !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL write_c1 got g0g1WeRd=%b adr=%h wd=%h exp=0110 adr=20 wd=12345678",
               {gnt0, gnt1, memWe, memRd}, memAdr, memwrData);
    end
    adr1 = 32'h24; wdata1 = 32'hA5A5_5A5A;
    tick();  // cycle 2
    vectors++;
    if ({gnt1, memWe, rvalid0, rvalid1} !== 4'b0000 || memAdr !== 32'h20) begin
      miscompares++;
      $display("FAIL write_c2 got g1WeRv0Rv1=%b adr=%h exp=0000 adr=20", {gnt1, memWe, rvalid0, rvalid1}, memAdr);
    end
    tick();  // cycle 3
    vectors++;
    if ({gnt1, memWe} !== 2'b11 || memAdr !== 32'h24 || memwrData !== 32'hA5A5_5A5A) begin
      miscompares++;
      $display("FAIL write_c3 got g1We=%b adr=%h wd=%h exp=11 adr=24 wd=a5a55a5a", {gnt1, memWe}, memAdr, memwrData);
    end
    req1 = 0;
    tick();
    tick();
    vectors++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      miscompares++;
      $display("FAIL write_no_rvalid got=%b exp=00", {rvalid0, rvalid1});
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    apply_reset();
    req0 = 1; we0 = 1; adr0 = 32'h1000; wdata0 = 32'h1;
    req1 = 1; we1 = 1; adr1 = 32'h2000; wdata1 = 32'h2;
    for (int c = 1; c <= 8; c++) begin
      tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_g = (c % 2 == 1) ? 2'b10 : 2'b00;
`else
      exp_g = (c == 1 || c == 5) ? 2'b10 : (c == 3 || c == 7) ? 2'b01 : 2'b00;
`endif
      vectors++;
      if ({gnt0, gnt1} !== exp_g) begin
        miscompares++;
        $display("FAIL contention_c%0d got g0g1=%b exp=%b", c, {gnt0, gnt1}, exp_g);
      end
      if (exp_g != 2'b00) begin
        vectors++;
        if (memWe !== 1'b1 || memAdr !== (exp_g[1] ? 32'h1000 : 32'h2000)) begin
          miscompares++;
          $display("FAIL contention_adr_c%0d got We=%b adr=%h exp We=1 adr=%h", c, memWe, memAdr,
                   exp_g[1] ? 32'h1000 : 32'h2000);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_latency();
    logic [3:0] exp_o;
    apply_reset();
    req0 = 1; we0 = 0; adr0 = 32'h44;
    tick();  // cycle 1
    vectors++;
    if ({gnt0_l3, memRd_l3, memWe_l3} !== 3'b110 || memAdr_l3 !== 32'h44) begin
      miscompares++;
      $display("FAIL lat_c1 got g0RdWe=%b adr=%h exp=110 adr=44", {gnt0_l3, memRd_l3, memWe_l3}, memAdr_l3);
    end
    req0 = 0;
    for (int c = 2; c <= 7; c++) begin
      tick();
      memrdData = (c == 4) ? 32'hCAFE_F00D : GARB;
      if (c == 2) begin
        req1 = 1; we1 = 1; adr1 = 32'h88; wdata1 = 32'h77;
      end
      // {gnt0, gnt1, rvalid0, memWe}
      exp_o = (c == 5) ? 4'b0010 : (c == 7) ? 4'b0101 : 4'b0000;
      vectors++;
      if ({gnt0_l3, gnt1_l3, rvalid0_l3, memWe_l3} !== exp_o) begin
        miscompares++;
        $display("FAIL lat_c%0d got g0g1Rv0We=%b exp=%b", c, {gnt0_l3, gnt1_l3, rvalid0_l3, memWe_l3}, exp_o);
      end
      if (c == 5) begin
        vectors++;
        if (rdata_l3 !== 32'hCAFE_F00D) begin
          miscompares++;
          $display("FAIL lat_rdata got=%h exp=cafef00d", rdata_l3);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    req0 = 1; we0 = 0; adr0 = 32'h300;
    tick();  // cycle 1
    req0 = 0;
    tick();  // cycle 2: RWAIT
    reset = 1;
    memrdData = 32'h5555_AAAA;
    tick();  // cycle 3
    reset = 0;
    memrdData = GARB;
    vectors++;
    if ({gnt0, gnt1, rvalid0, rvalid1, memWe, memRd} !== 6'b0 || memAdr !== 32'h0 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_zero got strobes=%b adr=%h rdata=%h exp 0",
               {gnt0, gnt1, rvalid0, rvalid1, memWe, memRd}, memAdr, rdata);
    end
    for (int c = 4; c <= 5; c++) begin
      tick();
      vectors++;
      if ({rvalid0, gnt0, gnt1} !== 3'b000) begin
        miscompares++;
        $display("FAIL midrst_quiet_c%0d got rv0g0g1=%b exp=000", c, {rvalid0, gnt0, gnt1});
      end
    end
    req0 = 1; we0 = 1; adr0 = 32'h10;
    req1 = 1; we1 = 1; adr1 = 32'h20;
    tick();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin
      miscompares++;
      $display("FAIL midrst_first_tie got g0g1=%b exp=10", {gnt0, gnt1});
    end
    idle_inputs();
  endtask

  task automatic test_busy_ignore();
    apply_reset();
    req0 = 1; we0 = 0; adr0 = 32'h500;
    tick();  // cycle 1
    req0 = 0;
    tick();  // cycle 2: RWAIT, capture cycle
    req1 = 1; we1 = 0; adr1 = 32'h600;
    memrdData = 32'h1111_1111;
    tick();  // cycle 3: RESP
    memrdData = GARB;
    vectors++;
    if ({rvalid0, rvalid1, gnt1} !== 3'b100 || rdata !== 32'h1111_1111) begin
      miscompares++;
      $display("FAIL busy_c3 got rv0rv1g1=%b rdata=%h exp=100 rdata=11111111", {rvalid0, rvalid1, gnt1}, rdata);
    end
    tick();  // cycle 4: IDLE
    vectors++;
    if ({rvalid0, rvalid1, gnt1} !== 3'b000) begin
      miscompares++;
      $display("FAIL busy_c4 got rv0rv1g1=%b exp=000", {rvalid0, rvalid1, gnt1});
    end
    tick();  // cycle 5
    vectors++;
    if ({gnt0, gnt1, memRd} !== 3'b011 || memAdr !== 32'h600) begin
      miscompares++;
      $display("FAIL busy_c5 got g0g1Rd=%b adr=%h exp=011 adr=600", {gnt0, gnt1, memRd}, memAdr);
    end
    req1 = 0;
    tick();  // cycle 6
    memrdData = 32'h2222_2222;
    tick();  // cycle 7
    memrdData = GARB;
    vectors++;
    if ({rvalid0, rvalid1} !== 2'b01 || rdata !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL busy_c7 got rv0rv1=%b rdata=%h exp=01 rdata=22222222", {rvalid0, rvalid1}, rdata);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_latency();
    test_reset_mid_read();
    test_busy_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
